fft_r4_output_reorder: RTL and testbench
========================================

Name: fft_r4_output_reorder

Overview:
- Downstream stage of the four-sub-FFT combiner. Consumes its four parallel radix-4 output samples per beat over NFFT/4 beats.
- Reorders them into natural bin order and emits one complex sample per cycle on a ready/valid stream.
- Ping-pong double buffer, so back-to-back frames from the combiner are absorbed while the previous frame drains.

Parameters:
- SIZE_BUFFER, 6, log2(NFFT); legal range 2..12.
- SIZE_DATA, 16, width of each I/Q component, two's complement; passed through unmodified.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- flush  in  1  synchronous frame abort, active-high.
- in_valid  in  1  beat valid; driven by the combiner's dataComplete.
- in_data0_i / in_data0_q  in  SIZE_DATA each  bin k.
- in_data1_i / in_data1_q  in  SIZE_DATA each  bin k+NFFT/4.
- in_data2_i / in_data2_q  in  SIZE_DATA each  bin k+NFFT/2.
- in_data3_i / in_data3_q  in  SIZE_DATA each  bin k+3NFFT/4.
- in_ready  out  1  high when the current write bank can accept a beat.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accept.
- out_data_i / out_data_q  out  SIZE_DATA each  reordered sample.
- out_index  out  SIZE_BUFFER  bin number of the current output.
- out_last  out  1  high with bin NFFT-1.
- overflow  out  1  sticky; set when a beat arrives while in_ready=0.

Behaviour:
- Storage: two banks of NFFT complex words, wr_bank and rd_bank pointers, and one full flag per bank. Banks and pointers start at bank 0.
- Write side:
  - Beat counter k runs 0..NFFT/4-1 and advances only on in_valid&&in_ready.
  - Accepted beat k writes data0..3 to addresses k, k+NFFT/4, k+NFFT/2, k+3NFFT/4 of wr_bank in the same edge.
  - Gaps in in_valid are allowed; the frame resumes at the held k.
  - On acceptance of beat NFFT/4-1: full[wr_bank] is set, k wraps to 0 and wr_bank toggles, all on that edge.
- in_ready = !full[wr_bank] (combinational).
- in_valid while in_ready=0: the beat is dropped, nothing is written, and overflow is set until reset or flush.
- Read FSM:
  - IDLE: when full[rd_bank]=1, issue a read of address 0 and go to READ.
  - READ: present sample n. On out_valid&&out_ready, advance n. Any read pipeline stays inside this block.
  - Accept of n=NFFT-1 (out_last=1): clear full[rd_bank], toggle rd_bank, n=0. If the other bank is already full, stay in READ; otherwise go to IDLE.
- Latency:
  - out_valid first rises on the 2nd rising edge after the edge that accepted the final input beat.
  - With out_ready held high: one sample per cycle, no bubbles within a frame.
  - At most 2 out_valid-low cycles between back-to-back frames.
- Stall: while out_valid=1 and out_ready=0, out_data_i/q, out_index and out_last hold stable, and out_valid stays high.
- Simultaneous events: a bank becoming full on the same edge that the other bank is freed is legal. Both flag updates take effect.
- Reset values (reset=0, asynchronous): out_valid=0, in_ready=1, out_data_i/q=0, out_index=0, out_last=0, overflow=0, both full flags=0, k=0, n=0, FSM=IDLE.
  - Memory contents are not reset.
  - Reset mid-frame discards the partial frame.
- flush=1 at an edge: same state as reset, but applied synchronously; it overrides in_valid and out_ready on that edge.
- No arithmetic is performed. Data is bit-exact from input to output.

Test Plan:
- Single frame, SIZE_BUFFER=4 (NFFT=16), out_ready=1.
  - Stimulus: 4 contiguous beats; beat k has data0=k, data1=4+k, data2=8+k, data3=12+k (i=q=value).
  - Required: out_data_i = 0,1,...,15 on 16 consecutive cycles; out_index matches; out_last only on 15; first out_valid 2 edges after beat 3.
- Back-to-back frames, NFFT=16.
  - Stimulus: 3 frames of 4 beats with no gaps; frame f adds 16*f to every value.
  - Required: outputs 0..47 in order; ≤2 invalid cycles between frames; overflow=0.
- Backpressure.
  - Stimulus: out_ready toggles 1,0,0,1 pattern during readout.
  - Required: each of 0..15 appears exactly once, held stable while stalled.
- Overflow.
  - Stimulus: out_ready=0, send 3 full frames.
  - Required: in_ready=0 after frame 2; frame 3 is dropped and overflow=1. After out_ready=1, frames 1 and 2 output intact.
- Gapped input.
  - Stimulus: beats spaced 3 cycles apart.
  - Required: same output as the single-frame case.
- Abort.
  - Stimulus: assert flush after beat 2, then assert reset=0 mid-readout in a separate run.
  - Required: all outputs go to their reset values; the next full frame outputs 0..15 correctly.

Source files
------------

// File: rtl/fft_r4_output_reorder.sv
// Reorders radix-4 combiner beats (four bins per beat) into a natural-order complex sample stream.
// Latency: first out_valid two edges after the edge accepting a frame's final beat; one sample/cycle after.
// Backpressure: out_ready low holds the output sample; in_ready drops while the write bank is still full.
module fft_r4_output_reorder #(
    parameter int SIZE_BUFFER = 6,
    parameter int SIZE_DATA   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [SIZE_DATA-1:0]   in_data0_i,
    input  logic [SIZE_DATA-1:0]   in_data0_q,
    input  logic [SIZE_DATA-1:0]   in_data1_i,
    input  logic [SIZE_DATA-1:0]   in_data1_q,
    input  logic [SIZE_DATA-1:0]   in_data2_i,
    input  logic [SIZE_DATA-1:0]   in_data2_q,
    input  logic [SIZE_DATA-1:0]   in_data3_i,
    input  logic [SIZE_DATA-1:0]   in_data3_q,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIZE_DATA-1:0]   out_data_i,
    output logic [SIZE_DATA-1:0]   out_data_q,
    output logic [SIZE_BUFFER-1:0] out_index,
    output logic                   out_last,
    output logic                   overflow
);

    localparam int NFFT = 1 << SIZE_BUFFER;
    localparam int QTR  = NFFT / 4;
    localparam logic [SIZE_BUFFER-1:0] K_LAST = SIZE_BUFFER'(QTR - 1);
    localparam logic [SIZE_BUFFER-1:0] N_LAST = SIZE_BUFFER'(NFFT - 1);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t state_q, state_d;

    logic [1:0]             full_q, full_d;
    logic                   wr_bank, rd_bank;
    logic [SIZE_BUFFER-1:0] k_q, n_q;
    logic                   wr_acc, wr_last, rd_acc_last, load;

    // Bank b occupies addresses {b, bin}
    logic [SIZE_DATA-1:0] mem_i [0:2*NFFT-1];
    logic [SIZE_DATA-1:0] mem_q [0:2*NFFT-1];

    logic [SIZE_DATA-1:0] din_i [4];
    logic [SIZE_DATA-1:0] din_q [4];

    assign din_i[0] = in_data0_i;
    assign din_i[1] = in_data1_i;
    assign din_i[2] = in_data2_i;
    assign din_i[3] = in_data3_i;
    assign din_q[0] = in_data0_q;
    assign din_q[1] = in_data1_q;
    assign din_q[2] = in_data2_q;
    assign din_q[3] = in_data3_q;

    assign in_ready    = !full_q[wr_bank];
    assign wr_acc      = in_valid && in_ready && !flush;
    assign wr_last     = wr_acc && (k_q == K_LAST);
    assign rd_acc_last = out_valid && out_ready && out_last && !flush;

    always_comb begin
        full_d = full_q;
        if (wr_last) begin
            full_d[wr_bank] = 1'b1;
        end
        // Read and write banks differ whenever both fire, so both updates land
        if (rd_acc_last) begin
            full_d[rd_bank] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank]) begin
                    state_d = READ;
                end
            end
            READ: begin
                // Refill the output register unless it holds the frame's last bin
                if (!out_valid || (out_ready && !out_last)) begin
                    load = 1'b1;
                end
                if (rd_acc_last && !full_q[!rd_bank]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int j = 0; j < 4; j++) begin
                mem_i[{wr_bank, k_q + SIZE_BUFFER'(j * QTR)}] <= din_i[j];
                mem_q[{wr_bank, k_q + SIZE_BUFFER'(j * QTR)}] <= din_q[j];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            full_q     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            k_q        <= '0;
            n_q        <= '0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            out_data_i <= '0;
            out_data_q <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
        end else if (flush) begin
            state_q    <= IDLE;
            full_q     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            k_q        <= '0;
            n_q        <= '0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            out_data_i <= '0;
            out_data_q <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            if (wr_acc) begin
                k_q <= wr_last ? '0 : k_q + 1'b1;
            end
            if (wr_last) begin
                wr_bank <= ~wr_bank;
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            if (load) begin
                out_data_i <= mem_i[{rd_bank, n_q}];
                out_data_q <= mem_q[{rd_bank, n_q}];
                out_index  <= n_q;
                out_last   <= (n_q == N_LAST);
                out_valid  <= 1'b1;
                n_q        <= n_q + 1'b1;
            end else if (rd_acc_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                n_q       <= '0;
                rd_bank   <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft_r4_output_reorder.sv
// Scoreboard bench for fft_r4_output_reorder with NFFT=16.
module tb_fft_r4_output_reorder;

    localparam int SB = 4;
    localparam int DW = 16;
    localparam int NFFT = 1 << SB;
    localparam int QTR = NFFT / 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] din_i [4];
    logic [DW-1:0] din_q [4];
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data_i, out_data_q;
    logic [SB-1:0] out_index;
    logic          out_last;
    logic          overflow;

    typedef struct {
        logic [DW-1:0] val;
        logic [SB-1:0] idx;
        logic          last;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int       ready_mode = 0;
    logic [3:0] bp_pat = 4'b1001;
    int       bp_ph = 0;

    bit            gap_track = 0;
    int            gap_cnt = 0;
    bit            stall_prev = 0;
    logic [DW-1:0] held_i, held_q;
    logic [SB-1:0] held_idx;
    logic          held_last;

    fft_r4_output_reorder #(.SIZE_BUFFER(SB), .SIZE_DATA(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data0_i (din_i[0]),
        .in_data0_q (din_q[0]),
        .in_data1_i (din_i[1]),
        .in_data1_q (din_q[1]),
        .in_data2_i (din_i[2]),
        .in_data2_q (din_q[2]),
        .in_data3_i (din_i[3]),
        .in_data3_q (din_q[3]),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_i (out_data_i),
        .out_data_q (out_data_q),
        .out_index  (out_index),
        .out_last   (out_last),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: begin
                out_ready = bp_pat[bp_ph];
                bp_ph = (bp_ph + 1) % 4;
            end
        endcase
    end

    always @(negedge clk) begin
        if (!reset) begin
            gap_track  = 0;
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check_eq("stall_vld", out_valid, 1);
                check_eq("stall_i", out_data_i, held_i);
                check_eq("stall_q", out_data_q, held_q);
                check_eq("stall_idx", out_index, held_idx);
                check_eq("stall_last", out_last, held_last);
            end
            if (gap_track) begin
                if (out_valid) begin
                    check_eq("frame_gap_gt2", gap_cnt > 2, 0);
                    gap_track = 0;
                end else begin
                    gap_cnt++;
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("out_i", out_data_i, e.val);
                    check_eq("out_q", out_data_q, e.val + 16'h0100);
                    check_eq("out_idx", out_index, e.idx);
                    check_eq("out_last", out_last, e.last);
                end
                if (out_last) begin
                    gap_track = (sb.size() != 0);
                    gap_cnt   = 0;
                end
            end
            stall_prev = out_valid && !out_ready;
            held_i     = out_data_i;
            held_q     = out_data_q;
            held_idx   = out_index;
            held_last  = out_last;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input int base, input int k, input bit force_v);
        int t;
        t = 0;
        if (!force_v) begin
            while (!in_ready && t < 300) begin
                tick(1);
                t++;
            end
            if (t >= 300) check_eq("in_ready_timeout", in_ready, 1);
        end
        for (int j = 0; j < 4; j++) begin
            din_i[j] = 16'(base + j * QTR + k);
            din_q[j] = 16'(base + j * QTR + k) + 16'h0100;
        end
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input int gap, input bit push, input bit force_v);
        for (int k = 0; k < QTR; k++) begin
            send_beat(base, k, force_v);
            if (k < QTR - 1) tick(gap);
        end
        if (push) begin
            for (int n = 0; n < NFFT; n++) begin
                exp_t e;
                e.val  = 16'(base + n);
                e.idx  = SB'(n);
                e.last = (n == NFFT - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 1000) begin
            tick(1);
            t++;
        end
        check_eq("drain_left", sb.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_vld"}, out_valid, 0);
        check_eq({tag, "_inrdy"}, in_ready, 1);
        check_eq({tag, "_i"}, out_data_i, 0);
        check_eq({tag, "_q"}, out_data_q, 0);
        check_eq({tag, "_idx"}, out_index, 0);
        check_eq({tag, "_last"}, out_last, 0);
        check_eq({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        for (int j = 0; j < 4; j++) begin
            din_i[j] = '0;
            din_q[j] = '0;
        end
        @(posedge clk);
        #1;
        check_reset_vals("rst");
        tick(1);
        reset = 1'b1;
        ready_mode = 1;
        tick(2);

        // single frame with latency check
        send_frame(0, 0, 1, 0);
        @(negedge clk);
        check_eq("lat_e0", out_valid, 0);
        @(negedge clk);
        check_eq("lat_e1", out_valid, 0);
        @(negedge clk);
        check_eq("lat_e2", out_valid, 1);
        @(posedge clk);
        #1;
        wait_drain();

        // gapped input
        send_frame(16'h0200, 2, 1, 0);
        wait_drain();

        // back-to-back frames
        for (int f = 0; f < 3; f++) send_frame(16 * f, 0, 1, 0);
        wait_drain();
        check_eq("b2b_ovf", overflow, 0);

        // backpressure
        ready_mode = 2;
        send_frame(16'h0300, 0, 1, 0);
        wait_drain();

        // overflow
        ready_mode = 0;
        tick(2);
        send_frame(16'h0400, 0, 1, 0);
        send_frame(16'h0410, 0, 1, 0);
        tick(2);
        check_eq("ovf_inrdy", in_ready, 0);
        check_eq("ovf_pre", overflow, 0);
        send_frame(16'h0700, 0, 0, 1);
        check_eq("ovf_set", overflow, 1);
        check_eq("ovf_hold_vld", out_valid, 1);
        check_eq("ovf_hold_idx", out_index, 0);
        ready_mode = 1;
        wait_drain();
        check_eq("ovf_sticky", overflow, 1);

        // flush after beat 2
        for (int k = 0; k < 3; k++) send_beat(16'h0500, k, 0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check_reset_vals("flush");
        send_frame(16'h0600, 0, 1, 0);
        wait_drain();

        // reset mid-readout
        send_frame(16'h0800, 0, 1, 0);
        begin
            int t;
            t = 0;
            while (!(out_valid && out_index == 5) && t < 100) begin
                tick(1);
                t++;
            end
            check_eq("rst_mid_reached", out_index, 5);
        end
        #3;
        reset = 1'b0;
        #2;
        check_reset_vals("amid");
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1);
        send_frame(16'h0900, 0, 1, 0);
        wait_drain();
        check_eq("final_ovf", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
